// File: rtl/vga_renderer_pkg.sv
// Shared definitions for the VGA renderer: game-state codes, timing,
// sprite sizes, colours and position/hit helpers.
package vga_renderer_pkg;

  typedef enum logic [2:0] {
    GS_IDLE    = 3'd0,
    GS_INITIAL = 3'd1,
    GS_PLAYING = 3'd2,
    GS_VICTORY = 3'd3,
    GS_DEFEAT  = 3'd4,
    GS_ERROR   = 3'd5
  } game_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } pos_t;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int ENEMY_W_D  = 32;
  localparam int ENEMY_H_D  = 16;
  localparam int PLAYER_W_D = 32;
  localparam int PLAYER_H_D = 16;
  localparam int BULLET_W_D = 4;
  localparam int BULLET_H_D = 8;

  localparam logic [23:0] C_PLAYER  = 24'h00FF00;
  localparam logic [23:0] C_PBULLET = 24'hFFFF00;
  localparam logic [23:0] C_EBULLET = 24'hFF00FF;
  localparam logic [23:0] C_ENEMY   = 24'hFFFFFF;
  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_VICTORY = 24'h002000;
  localparam logic [23:0] C_DEFEAT  = 24'h200000;
  localparam logic [23:0] C_ERROR   = 24'h0000FF;

  function automatic pos_t pos_unpack(input logic [18:0] p);
    return pos_t'(p);
  endfunction

  function automatic logic [18:0] pos_pack(input pos_t p);
    return {p.x, p.y};
  endfunction

  function automatic logic [23:0] bg_colour(input game_state_e gs);
    logic [23:0] c;
    c = C_BLACK;
    case (gs)
      GS_VICTORY: c = C_VICTORY;
      GS_DEFEAT:  c = C_DEFEAT;
      GS_ERROR:   c = C_ERROR;
      default:    c = C_BLACK;
    endcase
    return c;
  endfunction

  // Signed 11-bit box test so centres near 0 extend off-screen cleanly.
  function automatic logic hit_test(
    input pos_t       p,
    input logic [9:0] h,
    input logic [9:0] v,
    input int         w,
    input int         hgt
  );
    logic signed [10:0] cx, cy, hx, vy, dw, dh;
    cx = {1'b0, p.x};
    cy = {2'b0, p.y};
    hx = {1'b0, h};
    vy = {1'b0, v};
    dw = 11'(w / 2);
    dh = 11'(hgt / 2);
    return (hx >= cx - dw) && (hx < cx + dw) &&
           (vy >= cy - dh) && (vy < cy + dh);
  endfunction

endpackage

// File: rtl/vga_renderer_timing.sv
// Pixel-enable generation, DAC clock and h/v raster counters with raw
// sync, active-region and snapshot strobes.
module vga_timing
  import vga_renderer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_Pe,
  output logic       o_DacClk,
  output logic [9:0] o_HCnt,
  output logic [9:0] o_VCnt,
  output logic       o_Active,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Snap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;

  logic       r_Pe;
  logic       r_DacClk;
  logic [9:0] r_HCnt;
  logic [9:0] r_VCnt;

  // DAC clock lags pe by one cycle, i.e. equals ~pe, so its rising
  // edge sits in the middle of each stable pixel.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Pe     <= 1'b0;
      r_DacClk <= 1'b0;
      r_HCnt   <= '0;
      r_VCnt   <= '0;
    end else begin
      r_Pe     <= ~r_Pe;
      r_DacClk <= r_Pe;
      if (r_Pe) begin
        if (r_HCnt == 10'(H_TOTAL - 1)) begin
          r_HCnt <= '0;
          if (r_VCnt == 10'(V_TOTAL - 1)) r_VCnt <= '0;
          else                            r_VCnt <= r_VCnt + 10'd1;
        end else begin
          r_HCnt <= r_HCnt + 10'd1;
        end
      end
    end
  end

  assign o_Pe     = r_Pe;
  assign o_DacClk = r_DacClk;
  assign o_HCnt   = r_HCnt;
  assign o_VCnt   = r_VCnt;
  assign o_Active = (r_HCnt < 10'(H_ACTIVE)) && (r_VCnt < 10'(V_ACTIVE));
  assign o_HSync  = !((r_HCnt >= 10'(HS_LO)) && (r_HCnt <= 10'(HS_HI)));
  assign o_VSync  = !((r_VCnt >= 10'(VS_LO)) && (r_VCnt <= 10'(VS_HI)));
  assign o_Snap   = r_Pe && (r_HCnt == '0) && (r_VCnt == 10'(V_ACTIVE));

endmodule

// File: rtl/vga_renderer.sv
// Game-state consumer: per-frame shadow snapshot, two-stage hit/colour
// pipeline and VGA DAC outputs.
module vga_renderer
  import vga_renderer_pkg::*;
#(
  parameter int MAX_ENEMY         = 15,
  parameter int MAX_PLAYER_BULLET = 4,
  parameter int H_ACTIVE          = H_ACTIVE_D,
  parameter int H_FP              = H_FP_D,
  parameter int H_SYNC            = H_SYNC_D,
  parameter int H_BP              = H_BP_D,
  parameter int V_ACTIVE          = V_ACTIVE_D,
  parameter int V_FP              = V_FP_D,
  parameter int V_SYNC            = V_SYNC_D,
  parameter int V_BP              = V_BP_D,
  parameter int ENEMY_W           = ENEMY_W_D,
  parameter int ENEMY_H           = ENEMY_H_D,
  parameter int PLAYER_W          = PLAYER_W_D,
  parameter int PLAYER_H          = PLAYER_H_D,
  parameter int BULLET_W          = BULLET_W_D,
  parameter int BULLET_H          = BULLET_H_D
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic [2:0]                     i_GameState,
  input  logic [MAX_ENEMY-1:0]           i_EnemyState,
  input  logic [19*MAX_ENEMY-1:0]        i_EnemyPosition,
  input  logic [MAX_ENEMY-1:0]           i_EnemyBulletState,
  input  logic [19*MAX_ENEMY-1:0]        i_EnemyBulletPosition,
  input  logic                           i_PlayerState,
  input  logic [18:0]                    i_PlayerPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]   i_PlayerBulletState,
  input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPosition,
  output logic                           o_FrameTick,
  output logic                           o_Clk,
  output logic                           o_blank,
  output logic                           o_hsync,
  output logic                           o_vsync,
  output logic [7:0]                     o_Red,
  output logic [7:0]                     o_Green,
  output logic [7:0]                     o_Blue
);

  logic       w_Pe, w_Active, w_HSync, w_VSync, w_Snap;
  logic [9:0] w_HCnt, w_VCnt;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .o_Pe     (w_Pe),
    .o_DacClk (o_Clk),
    .o_HCnt   (w_HCnt),
    .o_VCnt   (w_VCnt),
    .o_Active (w_Active),
    .o_HSync  (w_HSync),
    .o_VSync  (w_VSync),
    .o_Snap   (w_Snap)
  );

  game_state_e                    r_GameState;
  logic [MAX_ENEMY-1:0]           r_EnemyState;
  logic [19*MAX_ENEMY-1:0]        r_EnemyPos;
  logic [MAX_ENEMY-1:0]           r_EBulletState;
  logic [19*MAX_ENEMY-1:0]        r_EBulletPos;
  logic                           r_PlayerState;
  logic [18:0]                    r_PlayerPos;
  logic [MAX_PLAYER_BULLET-1:0]   r_PBulletState;
  logic [19*MAX_PLAYER_BULLET-1:0] r_PBulletPos;
  logic                           r_FrameTick;

  // Shadow copy taken in vertical blank so the game can step tear-free.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_GameState    <= GS_IDLE;
      r_EnemyState   <= '0;
      r_EnemyPos     <= '0;
      r_EBulletState <= '0;
      r_EBulletPos   <= '0;
      r_PlayerState  <= 1'b0;
      r_PlayerPos    <= '0;
      r_PBulletState <= '0;
      r_PBulletPos   <= '0;
      r_FrameTick    <= 1'b0;
    end else begin
      r_FrameTick <= w_Snap;
      if (w_Snap) begin
        r_GameState    <= game_state_e'(i_GameState);
        r_EnemyState   <= i_EnemyState;
        r_EnemyPos     <= i_EnemyPosition;
        r_EBulletState <= i_EnemyBulletState;
        r_EBulletPos   <= i_EnemyBulletPosition;
        r_PlayerState  <= i_PlayerState;
        r_PlayerPos    <= i_PlayerPosition;
        r_PBulletState <= i_PlayerBulletState;
        r_PBulletPos   <= i_PlayerBulletPosition;
      end
    end
  end

  logic                         w_PlayerHit;
  logic [MAX_PLAYER_BULLET-1:0] w_PBulletHit;
  logic [MAX_ENEMY-1:0]         w_EBulletHit;
  logic [MAX_ENEMY-1:0]         w_EnemyHit;

  always_comb begin
    w_PBulletHit = '0;
    w_EBulletHit = '0;
    w_EnemyHit   = '0;
    w_PlayerHit  = r_PlayerState &&
      hit_test(pos_unpack(r_PlayerPos), w_HCnt, w_VCnt, PLAYER_W, PLAYER_H);
    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
      w_PBulletHit[k] = r_PBulletState[k] &&
        hit_test(pos_unpack(r_PBulletPos[19*k +: 19]),
                 w_HCnt, w_VCnt, BULLET_W, BULLET_H);
    end
    for (int k = 0; k < MAX_ENEMY; k++) begin
      w_EBulletHit[k] = r_EBulletState[k] &&
        hit_test(pos_unpack(r_EBulletPos[19*k +: 19]),
                 w_HCnt, w_VCnt, BULLET_W, BULLET_H);
      w_EnemyHit[k] = r_EnemyState[k] &&
        hit_test(pos_unpack(r_EnemyPos[19*k +: 19]),
                 w_HCnt, w_VCnt, ENEMY_W, ENEMY_H);
    end
  end

  logic                         r_s1_PlayerHit;
  logic [MAX_PLAYER_BULLET-1:0] r_s1_PBulletHit;
  logic [MAX_ENEMY-1:0]         r_s1_EBulletHit;
  logic [MAX_ENEMY-1:0]         r_s1_EnemyHit;
  logic                         r_s1_Active;
  logic                         r_s1_HSync;
  logic                         r_s1_VSync;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_s1_PlayerHit  <= 1'b0;
      r_s1_PBulletHit <= '0;
      r_s1_EBulletHit <= '0;
      r_s1_EnemyHit   <= '0;
      r_s1_Active     <= 1'b0;
      r_s1_HSync      <= 1'b1;
      r_s1_VSync      <= 1'b1;
    end else if (w_Pe) begin
      r_s1_PlayerHit  <= w_PlayerHit;
      r_s1_PBulletHit <= w_PBulletHit;
      r_s1_EBulletHit <= w_EBulletHit;
      r_s1_EnemyHit   <= w_EnemyHit;
      r_s1_Active     <= w_Active;
      r_s1_HSync      <= w_HSync;
      r_s1_VSync      <= w_VSync;
    end
  end

  logic [23:0] w_Colour;

  always_comb begin
    w_Colour = bg_colour(r_GameState);
    if (r_GameState != GS_IDLE) begin
      if (r_s1_PlayerHit)       w_Colour = C_PLAYER;
      else if (|r_s1_PBulletHit) w_Colour = C_PBULLET;
      else if (|r_s1_EBulletHit) w_Colour = C_EBULLET;
      else if (|r_s1_EnemyHit)   w_Colour = C_ENEMY;
    end
  end

  logic        r_Blank, r_HSync, r_VSync;
  logic [23:0] r_Rgb;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Blank <= 1'b0;
      r_HSync <= 1'b1;
      r_VSync <= 1'b1;
      r_Rgb   <= '0;
    end else if (w_Pe) begin
      r_Blank <= r_s1_Active;
      r_HSync <= r_s1_HSync;
      r_VSync <= r_s1_VSync;
      r_Rgb   <= r_s1_Active ? w_Colour : 24'h0;
    end
  end

  assign o_FrameTick = r_FrameTick;
  assign o_blank     = r_Blank;
  assign o_hsync     = r_HSync;
  assign o_vsync     = r_VSync;
  assign o_Red       = r_Rgb[23:16];
  assign o_Green     = r_Rgb[15:8];
  assign o_Blue      = r_Rgb[7:0];

endmodule

// File: doc/vga_renderer.md
Name: vga_renderer

Overview:
- Consumer side of the game-state interface: reads the entity states and positions published by the game logic and drives the 640x480@60 VGA DAC outputs (RGB, blank, hsync, vsync, DAC clock).
- Latches a shadow copy of all game state once per frame and returns a frame tick to the game logic, so the game can step once per frame without tearing.

Parameters:
- MAX_ENEMY, 15, number of enemies; also the number of enemy-bullet slots.
- MAX_PLAYER_BULLET, 4, number of player-bullet slots.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
- ENEMY_W/ENEMY_H, 32/16, enemy sprite box in pixels.
- PLAYER_W/PLAYER_H, 32/16, player sprite box in pixels.
- BULLET_W/BULLET_H, 4/8, bullet box (player and enemy).

Ports:
- i_Clk  in  1  50 MHz system clock.
- i_Rst  in  1  synchronous reset, active-high.
- i_GameState  in  3  game state code (IDLE/INITIAL/PLAYING/VICTORY/DEFEAT/ERROR).
- i_EnemyState  in  MAX_ENEMY  alive bit per enemy.
- i_EnemyPosition  in  19*MAX_ENEMY  packed {X[9:0],Y[8:0]} sprite centres; enemy k at [19k+18:19k].
- i_EnemyBulletState  in  MAX_ENEMY  active bit per enemy bullet.
- i_EnemyBulletPosition  in  19*MAX_ENEMY  packed enemy-bullet centres.
- i_PlayerState  in  1  player alive.
- i_PlayerPosition  in  19  player centre {X,Y}.
- i_PlayerBulletState  in  MAX_PLAYER_BULLET  active bit per player bullet.
- i_PlayerBulletPosition  in  19*MAX_PLAYER_BULLET  packed player-bullet centres.
- o_FrameTick  out  1  one-i_Clk pulse at the start of vertical blank.
- o_Clk  out  1  25 MHz DAC pixel clock.
- o_blank  out  1  DAC blank, active-low (0 = blanking).
- o_hsync, o_vsync  out  1 each  active-low syncs.
- o_Red, o_Green, o_Blue  out  8 each  pixel colour.

Behaviour:
- Clock and reset: single clock i_Clk; reset i_Rst is synchronous and active-high.
- Reset values:
  - pixel-enable toggle = 0, o_Clk = 0, h_cnt = 0, v_cnt = 0.
  - o_hsync = 1, o_vsync = 1, o_blank = 0, RGB = 0, o_FrameTick = 0.
  - All shadow states = 0; shadow game state = IDLE.
- Pixel enable (pe): toggles every i_Clk. o_Clk is a register equal to ~pe, so the DAC rising edge lands mid-way through stable data. Pipeline and counters advance only when pe = 1.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524 and wraps to 0.
  - Active region is h<640 && v<480.
  - hsync low for h in [656,751]; vsync low for v in [490,491].
- Snapshot:
  - When pe && h_cnt==0 && v_cnt==480, every input is copied into shadow registers.
  - o_FrameTick = 1 for exactly that i_Clk cycle.
  - Rendering reads only the shadow copy; input changes mid-frame have no visible effect.
- Pipeline: 2 pixel stages. Total latency from counter to pins is 2 pixel clocks, and sync/blank go through the same delay.
  - S1: registers per-entity hit bits.
  - S2: priority mux and output registers.
- Hit test: an entity hits when its state bit = 1 and cx - W/2 <= h < cx + W/2 and cy - H/2 <= v < cy + H/2. Compute in 11-bit signed arithmetic so a centre near 0 does not underflow or wrap.
- Colour priority: player > player bullet > enemy bullet > enemy > background.
  - player = 00FF00, player bullet = FFFF00, enemy bullet = FF00FF, enemy = FFFFFF.
  - Background: IDLE/INITIAL/PLAYING = 000000, VICTORY = 002000, DEFEAT = 200000, ERROR = 0000FF.
  - In IDLE, sprites are suppressed.
- Outside the active region: RGB = 0 and o_blank = 0, regardless of hits.
- Reset mid-frame: the next cycle matches the reset values exactly and the frame restarts at h = v = 0. The first frame after reset shows background only until the first snapshot.

Decomposition:
- Shared package:
  - game-state codes.
  - 19-bit position pack/unpack helpers.
  - VGA timing constants.
  - sprite sizes.
  - colour constants.
- Sub-module vga_timing: pe generation, h/v counters, raw sync/active/frame-tick outputs.
- vga_renderer: instantiates vga_timing and owns the shadow registers, hit pipeline and colour mux.

Test Plan:
- Reset for 3 cycles, then release: o_hsync=1, o_vsync=1, o_blank=0 and RGB=0 during reset; after release, the first hsync low edge occurs 2*(656+2)=1316 i_Clk later.
- Free-run one frame: 800 pixels per line and 525 lines per frame (840000 i_Clk); exactly one o_FrameTick per frame; vsync low for 2 lines; o_blank high only for the 640x480 region.
- PLAYING, player at {320,440}: pixels x∈[304,335], y∈[432,447] = 00FF00; pixel (336,440) = 000000.
- Player bullet and enemy overlap at the same centre {100,100}: the overlap pixel shows FFFF00. Then kill the bullet and wait one frame: the pixel shows FFFFFF.
- Enemy centre {5,5}: pixels x∈[0,20] drawn, no wrap artefact at x=629..639. Input position changed at v=200 mid-frame: no change until after the next o_FrameTick.
- Assert i_Rst at v=300: outputs return to reset values the next cycle; counters restart at 0; GameState=DEFEAT shows background 200000 after the next snapshot.
